// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: circular FIFO of {PC, instruction} between the I-cache and decode.
// The head entry is registered-only to decode; a flush empties the queue in one cycle.
module instr_fetch_queue #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 26,
   parameter int DATA_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_flush,
   input  logic                       i_valid,
   input  logic [ADDR_WIDTH-1:0]      i_pc,
   input  logic [DATA_WIDTH-1:0]      i_instr,
   output logic                       o_ready,
   output logic                       o_valid,
   output logic [ADDR_WIDTH-1:0]      o_pc,
   output logic [DATA_WIDTH-1:0]      o_instr,
   input  logic                       i_ready,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("instr_fetch_queue: DEPTH must be a power of 2 and at least 2");
      end
   endgenerate

   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
   logic [DATA_WIDTH-1:0] instr_mem [DEPTH];

   logic push;
   logic pop;

   // Handshake qualifiers depend only on registered occupancy, so neither
   // i_valid nor i_ready reaches any output combinationally.
   assign o_valid = (count != '0);
   assign o_ready = (count != CW'(DEPTH));
   assign push    = i_valid & o_ready & ~i_flush;
   assign pop     = o_valid & i_ready & ~i_flush;

   assign o_pc    = pc_mem[rd_ptr];
   assign o_instr = instr_mem[rd_ptr];
   assign o_count = count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage is left untouched by flush; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pc_mem[PW'(i)]    <= '0;
            instr_mem[PW'(i)] <= '0;
         end
      end else if (push) begin
         pc_mem[wr_ptr]    <= i_pc;
         instr_mem[wr_ptr] <= i_instr;
      end
   end

endmodule
